// File: rtl/paddle_pkg.sv
// Shared types, widths and tuning constants for the paddle input controller.
package paddle_pkg;
    localparam int VPOS_W  = 8;
    localparam int ARITH_W = 10;
    localparam int HOLD_W  = 5;

    localparam logic [VPOS_W-1:0] POS_MIN   = 8'd0;
    localparam logic [VPOS_W-1:0] POS_MAX   = 8'd255;
    localparam logic [VPOS_W-1:0] POS_RESET = 8'd128;
    localparam logic [VPOS_W-1:0] DEADBAND  = 8'd2;
    localparam logic [3:0]        STEP      = 4'd2;
    localparam logic [3:0]        ACCEL_MAX = 4'd6;

    typedef enum logic [1:0] {
        IDLE,
        SAMPLE_L,
        SAMPLE_R,
        COMMIT
    } state_t;

    function automatic logic [VPOS_W-1:0] clamp_vpos(input logic signed [ARITH_W-1:0] v);
        logic [VPOS_W-1:0] r;
        if (v < $signed({{(ARITH_W-VPOS_W){1'b0}}, POS_MIN}))
            r = POS_MIN;
        else if (v > $signed({{(ARITH_W-VPOS_W){1'b0}}, POS_MAX}))
            r = POS_MAX;
        else
            r = v[VPOS_W-1:0];
        return r;
    endfunction
endpackage

// File: rtl/paddle_step_unit.sv
// Combinational source arbitration, step and clamp for one player; zero latency, no flow control.
// Acceleration (hold counter) is present only when PADDLE_ACCEL_EN is defined.
module paddle_step_unit
    import paddle_pkg::*;
(
    input  logic [VPOS_W-1:0] ana,
    input  logic [VPOS_W-1:0] ana_prev,
    input  logic [VPOS_W-1:0] vpos,
    input  logic              src,
    input  logic              up,
    input  logic              dn,
`ifdef PADDLE_ACCEL_EN
    input  logic [HOLD_W-1:0] hold,
    input  logic              hold_dir,
    output logic [HOLD_W-1:0] next_hold,
    output logic              next_dir,
`endif
    output logic [VPOS_W-1:0] next_vpos,
    output logic              next_src
);
    logic                      btn;
    logic [VPOS_W-1:0]         adelta;
    logic [3:0]                step;
    logic signed [ARITH_W-1:0] base;
    logic signed [ARITH_W-1:0] moved;

    always_comb begin
        btn    = up | dn;
        adelta = (ana >= ana_prev) ? (ana - ana_prev) : (ana_prev - ana);
        if (btn)
            next_src = 1'b1;
        else if (adelta > DEADBAND)
            next_src = 1'b0;
        else
            next_src = src;
    end

`ifdef PADDLE_ACCEL_EN
    logic [HOLD_W-1:0] eff_hold;
    logic [HOLD_W-1:0] hold_cap;
    logic [3:0]        accel;

    // A held count only carries over while the same single direction stays pressed.
    always_comb begin
        hold_cap  = HOLD_W'(4 * ACCEL_MAX);
        eff_hold  = ((up ^ dn) && (hold_dir == dn)) ? hold : '0;
        accel     = (4'(eff_hold >> 2) > ACCEL_MAX) ? ACCEL_MAX : 4'(eff_hold >> 2);
        step      = STEP + accel;
        next_dir  = dn;
        if (!(up ^ dn))
            next_hold = '0;
        else if (eff_hold >= hold_cap)
            next_hold = hold_cap;
        else
            next_hold = eff_hold + 1'b1;
    end
`else
    always_comb step = STEP;
`endif

    always_comb begin
        base  = $signed({{(ARITH_W-VPOS_W){1'b0}}, vpos});
        moved = base;
        if (up && !dn)
            moved = base - $signed({{(ARITH_W-4){1'b0}}, step});
        else if (dn && !up)
            moved = base + $signed({{(ARITH_W-4){1'b0}}, step});
        next_vpos = next_src ? clamp_vpos(moved)
                             : clamp_vpos($signed({{(ARITH_W-VPOS_W){1'b0}}, ana}));
    end
endmodule

// File: rtl/paddle_input_ctrl.sv
// Per-frame paddle position controller; commits both players 3 cycles after the synced _v256 fall, no backpressure.
// Optional PADDLE_ACCEL_EN adds held-button acceleration.
module paddle_input_ctrl
    import paddle_pkg::*;
(
    input  logic              clk,
    input  logic              _reset,
    input  logic              _v256,
    input  logic [VPOS_W-1:0] ana_l,
    input  logic [VPOS_W-1:0] ana_r,
    input  logic              up_l,
    input  logic              dn_l,
    input  logic              up_r,
    input  logic              dn_r,
    output logic [VPOS_W-1:0] paddle_vpos_l,
    output logic [VPOS_W-1:0] paddle_vpos_r,
    output logic              src_l,
    output logic              src_r,
    output logic              frame_tick
);
    logic              v256_s1, v256_s2, v256_prev;
    logic              frame_start;
    state_t            state, state_nxt;

    logic [VPOS_W-1:0] sh_vpos_l, sh_vpos_r;
    logic              sh_src_l, sh_src_r;
    logic [VPOS_W-1:0] ana_prev_l, ana_prev_r;

    logic              sel_r;
    logic [VPOS_W-1:0] cur_ana, cur_prev, cur_vpos;
    logic              cur_src, cur_up, cur_dn;
    logic [VPOS_W-1:0] nxt_vpos;
    logic              nxt_src;

`ifdef PADDLE_ACCEL_EN
    logic [HOLD_W-1:0] hold_l, hold_r, cur_hold, nxt_hold;
    logic              dir_l, dir_r, cur_dir, nxt_dir;
`endif

    assign frame_start = v256_prev & ~v256_s2;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (frame_start) state_nxt = SAMPLE_L;
            SAMPLE_L: state_nxt = SAMPLE_R;
            SAMPLE_R: state_nxt = COMMIT;
            COMMIT:   state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!_reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // The single step unit sees the left player except during SAMPLE_R.
    always_comb begin
        sel_r    = (state == SAMPLE_R);
        cur_ana  = sel_r ? ana_r         : ana_l;
        cur_prev = sel_r ? ana_prev_r    : ana_prev_l;
        cur_vpos = sel_r ? paddle_vpos_r : paddle_vpos_l;
        cur_src  = sel_r ? src_r         : src_l;
        cur_up   = sel_r ? up_r          : up_l;
        cur_dn   = sel_r ? dn_r          : dn_l;
`ifdef PADDLE_ACCEL_EN
        cur_hold = sel_r ? hold_r        : hold_l;
        cur_dir  = sel_r ? dir_r         : dir_l;
`endif
    end

    paddle_step_unit u_step (
        .ana       (cur_ana),
        .ana_prev  (cur_prev),
        .vpos      (cur_vpos),
        .src       (cur_src),
        .up        (cur_up),
        .dn        (cur_dn),
`ifdef PADDLE_ACCEL_EN
        .hold      (cur_hold),
        .hold_dir  (cur_dir),
        .next_hold (nxt_hold),
        .next_dir  (nxt_dir),
`endif
        .next_vpos (nxt_vpos),
        .next_src  (nxt_src)
    );

    always_ff @(posedge clk) begin
        if (!_reset) begin
            v256_s1       <= 1'b1;
            v256_s2       <= 1'b1;
            v256_prev     <= 1'b1;
            sh_vpos_l     <= POS_RESET;
            sh_vpos_r     <= POS_RESET;
            sh_src_l      <= 1'b0;
            sh_src_r      <= 1'b0;
            ana_prev_l    <= POS_RESET;
            ana_prev_r    <= POS_RESET;
            paddle_vpos_l <= POS_RESET;
            paddle_vpos_r <= POS_RESET;
            src_l         <= 1'b0;
            src_r         <= 1'b0;
            frame_tick    <= 1'b0;
`ifdef PADDLE_ACCEL_EN
            hold_l        <= '0;
            hold_r        <= '0;
            dir_l         <= 1'b0;
            dir_r         <= 1'b0;
`endif
        end else begin
            v256_s1    <= _v256;
            v256_s2    <= v256_s1;
            v256_prev  <= v256_s2;
            frame_tick <= (state == COMMIT);
            case (state)
                SAMPLE_L: begin
                    sh_vpos_l  <= nxt_vpos;
                    sh_src_l   <= nxt_src;
                    ana_prev_l <= ana_l;
`ifdef PADDLE_ACCEL_EN
                    hold_l     <= nxt_hold;
                    dir_l      <= nxt_dir;
`endif
                end
                SAMPLE_R: begin
                    sh_vpos_r  <= nxt_vpos;
                    sh_src_r   <= nxt_src;
                    ana_prev_r <= ana_r;
`ifdef PADDLE_ACCEL_EN
                    hold_r     <= nxt_hold;
                    dir_r      <= nxt_dir;
`endif
                end
                COMMIT: begin
                    paddle_vpos_l <= sh_vpos_l;
                    paddle_vpos_r <= sh_vpos_r;
                    src_l         <= sh_src_l;
                    src_r         <= sh_src_r;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_paddle_input_ctrl.sv
// Directed bench for paddle_input_ctrl: frames driven through _v256, results checked when frame_tick rises.
module tb_paddle_input_ctrl;
    logic       clk = 1'b0;
    logic       reset_n;
    logic       v256;
    logic [7:0] ana_l, ana_r;
    logic       up_l, dn_l, up_r, dn_r;
    logic [7:0] paddle_vpos_l, paddle_vpos_r;
    logic       src_l, src_r, frame_tick;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    paddle_input_ctrl dut (
        .clk           (clk),
        ._reset        (reset_n),
        ._v256         (v256),
        .ana_l         (ana_l),
        .ana_r         (ana_r),
        .up_l          (up_l),
        .dn_l          (dn_l),
        .up_r          (up_r),
        .dn_r          (dn_r),
        .paddle_vpos_l (paddle_vpos_l),
        .paddle_vpos_r (paddle_vpos_r),
        .src_l         (src_l),
        .src_r         (src_r),
        .frame_tick    (frame_tick)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Leaves the bench on the cycle frame_tick is high (or after the budget expires).
    task automatic do_frame();
        bit seen;
        v256 = 1'b1;
        step();
        check("tick_single_cycle", frame_tick, 0);
        repeat (3) step();
        v256 = 1'b0;
        seen = 1'b0;
        for (int n = 0; n < 20 && !seen; n++) begin
            step();
            if (frame_tick) seen = 1'b1;
        end
        check("frame_tick_seen", seen, 1);
    endtask

    task automatic check_l(input string tag, input int vpos, input int src);
        check({tag, "_vpos_l"}, paddle_vpos_l, vpos);
        check({tag, "_src_l"}, src_l, src);
    endtask

    task automatic check_r(input string tag, input int vpos, input int src);
        check({tag, "_vpos_r"}, paddle_vpos_r, vpos);
        check({tag, "_src_r"}, src_r, src);
    endtask

    initial begin
        int ticks;
        int exp_v;
        int hold;
        int st;

        reset_n = 1'b0;
        v256    = 1'b1;
        ana_l   = 8'd128;
        ana_r   = 8'd128;
        up_l = 0; dn_l = 0; up_r = 0; dn_r = 0;

        // Reset with _v256 toggling: no ticks, reset outputs.
        ticks = 0;
        for (int i = 0; i < 8; i++) begin
            v256 = ~v256;
            step();
            if (frame_tick) ticks++;
        end
        check_l("reset", 128, 0);
        check_r("reset", 128, 0);
        check("reset_tick", frame_tick, 0);
        reset_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            if (frame_tick) ticks++;
        end
        check("no_tick_before_edge", ticks, 0);

        // Steady analog left.
        ana_l = 8'd200;
        do_frame();
        check_l("ana200", 200, 0);
        check_r("ana200", 128, 0);
        ana_l = 8'd201;
        do_frame();
        check_l("ana201", 201, 0);

        // Digital up on left clamps at POS_MIN.
        ana_l = 8'd3;
        do_frame();
        check_l("ana3", 3, 0);
        up_l = 1'b1;
        do_frame();
        check_l("up_f1", 1, 1);
        do_frame();
        check_l("up_f2", 0, 1);
        do_frame();
        check_l("up_f3", 0, 1);
        up_l = 1'b0;
        do_frame();
        check_l("up_release_hold", 0, 1);

        // Right player: buttons beat analog, deadband boundary, both-buttons hold, upper clamp.
        ana_r = 8'd10;
        do_frame();
        check_r("ana10", 10, 0);
        up_r = 1'b1; ana_r = 8'd90;
        do_frame();
        check_r("btn_beats_ana", 8, 1);
        up_r = 1'b0; ana_r = 8'd95;
        do_frame();
        check_r("back_to_ana", 95, 0);
        dn_r = 1'b1;
        do_frame();
        check_r("dn_r", 97, 1);
        dn_r = 1'b0; ana_r = 8'd97;
        do_frame();
        check_r("deadband_eq", 97, 1);
        ana_r = 8'd100;
        do_frame();
        check_r("deadband_over", 100, 0);
        up_r = 1'b1; dn_r = 1'b1;
        do_frame();
        check_r("both_btn", 100, 1);
        up_r = 1'b0; dn_r = 1'b0; ana_r = 8'd254;
        do_frame();
        check_r("ana254", 254, 0);
        dn_r = 1'b1;
        do_frame();
        check_r("clamp_max1", 255, 1);
        do_frame();
        check_r("clamp_max2", 255, 1);
        dn_r = 1'b0;

        // Held down on left from 100; acceleration only when enabled.
        ana_l = 8'd100;
        do_frame();
        check_l("ana100", 100, 0);
        exp_v = 100;
        hold  = 0;
        dn_l  = 1'b1;
        for (int f = 0; f < 26; f++) begin
            st = 2;
`ifdef PADDLE_ACCEL_EN
            st = 2 + (((hold >> 2) > 6) ? 6 : (hold >> 2));
            hold = (hold + 1 > 24) ? 24 : hold + 1;
`endif
            exp_v = (exp_v + st > 255) ? 255 : exp_v + st;
            do_frame();
            check("dn_hold_vpos_l", paddle_vpos_l, exp_v);
        end
        dn_l = 1'b0;
        do_frame();
        check_l("dn_released", exp_v, 1);
        dn_l = 1'b1;
        do_frame();
        check_l("dn_restart", exp_v + 2, 1);
        dn_l = 1'b0;

        // Reset during SAMPLE_R abandons the frame.
        v256 = 1'b1;
        repeat (4) step();
        ana_l = 8'd50;
        v256  = 1'b0;
        ticks = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (frame_tick) ticks++;
        end
        reset_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            if (frame_tick) ticks++;
        end
        v256 = 1'b1;
        step();
        if (frame_tick) ticks++;
        check("midreset_no_tick", ticks, 0);
        check_l("midreset", 128, 0);
        check_r("midreset", 128, 0);
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            if (frame_tick) ticks++;
        end
        check("post_reset_no_tick", ticks, 0);
        do_frame();
        check_l("post_reset", 50, 0);
        check_r("post_reset", 254, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
